// File: rtl/mu0_memory_if.sv
// MU0 memory bus bundle: byte loader stream, processor bus and status/IO outputs.
interface mu0_memory_if;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_rst;
  logic [11:0] address;
  logic [15:0] data_out;
  logic        memory_read;
  logic        memory_write;
  logic [15:0] data_in;
  logic [15:0] io_out;
  logic        io_strobe;
  logic        addr_err;
  logic [10:0] loaded_words;

  modport master (
    output ld_valid, ld_data, ld_last, address, data_out, memory_read, memory_write,
    input  ld_ready, cpu_rst, data_in, io_out, io_strobe, addr_err, loaded_words
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, address, data_out, memory_read, memory_write,
    output ld_ready, cpu_rst, data_in, io_out, io_strobe, addr_err, loaded_words
  );
endinterface

// File: rtl/mu0_memory.sv
// MU0 RAM with a byte-stream boot loader that holds the CPU in reset until the image is in.
// Reads are combinational in RUN; writes and loader bytes land on the rising edge.
module mu0_memory #(
  parameter int          DEPTH   = 1024,
  parameter logic [11:0] IO_ADDR = 12'hFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  mu0_memory_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RELEASE, RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_ptr;
  logic [7:0]    r_hi;
  logic [15:0]   r_mem [DEPTH];
  logic [15:0]   r_io_out;
  logic          r_io_strobe;
  logic          r_addr_err;

  logic          w_ld_ready;
  logic          w_cpu_rst;
  logic          w_run;
  logic          w_acc;
  logic          w_ld_wr;
  logic [15:0]   w_ld_word;
  logic          w_in_ram;
  logic          w_is_io;
  logic          w_cpu_ram_wr;
  logic          w_cpu_io_wr;
  logic          w_cpu_bad_wr;
  logic          w_unused_rd;

  // Read strobe is irrelevant: data_in is always driven from the addressed location.
  assign w_unused_rd = bus.memory_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD_HI;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD_HI: if (w_acc) w_state_nxt = bus.ld_last ? RELEASE : LOAD_LO;
      LOAD_LO: if (w_acc) w_state_nxt = (bus.ld_last || r_ptr == PW'(DEPTH - 1)) ? RELEASE : LOAD_HI;
      RELEASE: w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = LOAD_HI;
    endcase
  end

  always_comb begin
    w_ld_ready = 1'b0;
    w_cpu_rst  = 1'b1;
    w_run      = 1'b0;
    case (r_state)
      LOAD_HI, LOAD_LO: w_ld_ready = 1'b1;
      RUN: begin
        w_cpu_rst = 1'b0;
        w_run     = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_acc     = bus.ld_valid && w_ld_ready;
  assign w_ld_wr   = w_acc && ((r_state == LOAD_HI && bus.ld_last) || r_state == LOAD_LO);
  assign w_ld_word = (r_state == LOAD_LO) ? {r_hi, bus.ld_data} : {bus.ld_data, 8'h00};

  assign w_in_ram     = 32'(bus.address) < DEPTH;
  assign w_is_io      = bus.address == IO_ADDR;
  assign w_cpu_ram_wr = w_run && bus.memory_write && w_in_ram;
  assign w_cpu_io_wr  = w_run && bus.memory_write && !w_in_ram && w_is_io;
  assign w_cpu_bad_wr = w_run && bus.memory_write && !w_in_ram && !w_is_io;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_hi  <= '0;
    end else begin
      if (w_acc && r_state == LOAD_HI) r_hi <= bus.ld_data;
      if (w_ld_wr) r_ptr <= r_ptr + 1'b1;
    end
  end

  // RAM has no reset so an image survives a processor restart.
  always_ff @(posedge clk) begin
    if (w_ld_wr)           r_mem[r_ptr[AW-1:0]]       <= w_ld_word;
    else if (w_cpu_ram_wr) r_mem[bus.address[AW-1:0]] <= bus.data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_io_out    <= '0;
      r_io_strobe <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_io_strobe <= w_cpu_io_wr;
      if (w_cpu_io_wr)  r_io_out   <= bus.data_out;
      if (w_cpu_bad_wr) r_addr_err <= 1'b1;
    end
  end

  always_comb begin
    bus.data_in = 16'h0000;
    if (w_run) begin
      if (w_in_ram)     bus.data_in = r_mem[bus.address[AW-1:0]];
      else if (w_is_io) bus.data_in = r_io_out;
    end
  end

  assign bus.ld_ready     = w_ld_ready;
  assign bus.cpu_rst      = w_cpu_rst;
  assign bus.io_out       = r_io_out;
  assign bus.io_strobe    = r_io_strobe;
  assign bus.addr_err     = r_addr_err;
  assign bus.loaded_words = 11'(r_ptr);
endmodule
